// File: rtl/agc_pkg.sv
// agc_pkg: shared constants, GOJAM state type and G-word packing for the reduced AGC core
package agc_pkg;
    localparam int MCT_LEN = 12;
    localparam int STEP_W = $clog2(MCT_LEN);
    localparam logic [MCT_LEN-1:0] TP_ONE = MCT_LEN'(1);
    localparam logic [11:0] Z_RESTART = 12'o4000;
    localparam int T01 = 0;
    localparam int T07 = 6;
    localparam int T12 = 11;
    localparam int G_SIGN = 15;
    localparam int G_ZERO = 14;

    typedef enum logic [1:0] {
        GJ_IDLE,
        GJ_ARMED,
        GJ_JAM
    } gojam_e;

    // Sense-amp word as latched into G: sign on top, bit 14 always clear
    function automatic logic [15:0] pack_g(input logic sign, input logic [13:0] mag);
        logic [15:0] w;
        w = {2'b00, mag};
        w[G_SIGN] = sign;
        w[G_ZERO] = 1'b0;
        return w;
    endfunction
endpackage

// File: rtl/agc_timepulse_gen.sv
// agc_timepulse_gen: one-hot T01..T12 rotator with standby freeze and monitor stop/step hold
module agc_timepulse_gen
    import agc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sby,
    input  logic               mstp,
    input  logic               mstrtp,
    output logic [MCT_LEN-1:0] tp,
    output logic               mct
);
    logic [STEP_W-1:0] cur_q, cur_d;
    logic act_q, act_d;
    logic hlt_q, hlt_d;
    logic mstrtp_q;
    logic last, adv, rel, step_edge;

    // cur is the step shown (or held while dark); a dark generator relights on the held step
    always_comb begin
        last = cur_q == STEP_W'(MCT_LEN - 1);
        step_edge = mstrtp & ~mstrtp_q;
        adv = act_q & ~sby;
        rel = ~act_q & ~sby & (~hlt_q | ~mstp | step_edge);
        cur_d = adv ? (last ? '0 : cur_q + STEP_W'(1)) : cur_q;
        act_d = sby ? 1'b0 : act_q ? ~(last & mstp) : rel;
        hlt_d = sby ? hlt_q : act_q ? (last & mstp) : (hlt_q & ~rel);
    end

    // sequencer state; reset leaves the generator dark and poised on T01
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_q    <= '0;
            act_q    <= 1'b0;
            hlt_q    <= 1'b0;
            mstrtp_q <= 1'b0;
        end else begin
            cur_q    <= cur_d;
            act_q    <= act_d;
            hlt_q    <= hlt_d;
            mstrtp_q <= mstrtp;
        end
    end

    assign tp  = act_q ? TP_ONE << cur_q : '0;
    assign mct = tp[T12];
endmodule

// File: rtl/agc_core.sv
// agc_core: reduced Block II AGC core - timepulses, GOJAM restart, G and Z registers
module agc_core
    import agc_pkg::*;
(
    input  logic               CLOCK,
    input  logic               SIM_RST_n,
    input  logic               STRT1,
    input  logic               STRT2,
    input  logic               MSTP,
    input  logic               MSTRTP,
    input  logic               SBY,
    input  logic               SA01,
    input  logic               SA02,
    input  logic               SA03,
    input  logic               SA04,
    input  logic               SA05,
    input  logic               SA06,
    input  logic               SA07,
    input  logic               SA08,
    input  logic               SA09,
    input  logic               SA10,
    input  logic               SA11,
    input  logic               SA12,
    input  logic               SA13,
    input  logic               SA14,
    input  logic               SA16,
    input  logic               ALGA,
    input  logic               C24A,
    input  logic               C25A,
    input  logic               C26A,
    input  logic               C27A,
    input  logic               C30A,
    input  logic               C31A,
    input  logic               C32A,
    input  logic               C33A,
    input  logic               C34A,
    input  logic               C35A,
    input  logic               C36A,
    input  logic               C37P,
    input  logic               C40P,
    input  logic               C41P,
    input  logic               C42P,
    input  logic               C43P,
    input  logic               C44P,
    input  logic               CH01,
    input  logic               CH02,
    input  logic               CH03,
    input  logic               CH04,
    input  logic               CH05,
    input  logic               CH06,
    input  logic               CH07,
    input  logic               CH08,
    input  logic               CH09,
    input  logic               CH10,
    input  logic               CH11,
    input  logic               CH12,
    input  logic               CH13,
    input  logic               CH14,
    input  logic               CH15,
    input  logic               CH16,
    input  logic               MDT01,
    input  logic               MDT02,
    input  logic               MDT03,
    input  logic               MDT04,
    input  logic               MDT05,
    input  logic               MDT06,
    input  logic               MDT07,
    input  logic               MDT08,
    input  logic               MDT09,
    input  logic               MDT10,
    input  logic               MDT11,
    input  logic               MDT12,
    input  logic               MDT13,
    input  logic               MDT14,
    input  logic               MDT15,
    input  logic               MDT16,
    input  logic               XB0_n,
    input  logic               XT0_n,
    input  logic               YB0_n,
    input  logic               YT0_n,
    input  logic               VCC,
    input  logic               GND,
    output logic [MCT_LEN-1:0] TP,
    output logic               MCT,
    output logic               GOJAM,
    output logic [15:0]        G,
    output logic [11:0]        Z
);
    gojam_e      st_q, st_d;
    logic        strt_q, pnd_q, pnd_d, req, gojam;
    logic [15:0] g_q, g_d, sa_w;
    logic [11:0] z_q, z_d;
    logic        unused_rsv;

    agc_timepulse_gen u_tpg (
        .clk    (CLOCK),
        .rst_n  (SIM_RST_n),
        .sby    (SBY),
        .mstp   (MSTP),
        .mstrtp (MSTRTP),
        .tp     (TP),
        .mct    (MCT)
    );

    // Harness signals carried for pin compatibility only
    assign unused_rsv = ^{ALGA, C24A, C25A, C26A, C27A, C30A, C31A, C32A, C33A, C34A, C35A,
                          C36A, C37P, C40P, C41P, C42P, C43P, C44P,
                          CH01, CH02, CH03, CH04, CH05, CH06, CH07, CH08,
                          CH09, CH10, CH11, CH12, CH13, CH14, CH15, CH16,
                          MDT01, MDT02, MDT03, MDT04, MDT05, MDT06, MDT07, MDT08,
                          MDT09, MDT10, MDT11, MDT12, MDT13, MDT14, MDT15, MDT16,
                          XB0_n, XT0_n, YB0_n, YT0_n, VCC, GND};

    // Start edges seen in standby stay pending; ARMED waits for a fresh T01 so JAM spans a full MCT
    always_comb begin
        sa_w  = pack_g(SA16, {SA14, SA13, SA12, SA11, SA10, SA09, SA08,
                              SA07, SA06, SA05, SA04, SA03, SA02, SA01});
        gojam = st_q != GJ_IDLE;
        req   = ((STRT1 | STRT2) & ~strt_q) | pnd_q;
        pnd_d = SBY & req;
        st_d  = SBY ? st_q :
                req ? GJ_ARMED :
                (st_q == GJ_ARMED && TP[T01]) ? GJ_JAM :
                (st_q == GJ_JAM && TP[T12]) ? GJ_IDLE : st_q;
        g_d   = SBY ? g_q : gojam ? '0 : TP[T07] ? sa_w : g_q;
        z_d   = (SBY || !TP[T12]) ? z_q : gojam ? Z_RESTART : z_q + 12'd1;
    end

    // Restart state, start edge history and the G/Z registers
    always_ff @(posedge CLOCK) begin
        if (!SIM_RST_n) begin
            st_q   <= GJ_IDLE;
            strt_q <= 1'b0;
            pnd_q  <= 1'b0;
            g_q    <= '0;
            z_q    <= '0;
        end else begin
            st_q   <= st_d;
            strt_q <= STRT1 | STRT2;
            pnd_q  <= pnd_d;
            g_q    <= g_d;
            z_q    <= z_d;
        end
    end

    assign GOJAM = gojam;
    assign G     = g_q;
    assign Z     = z_q;
endmodule

// File: tb/tb_agc_core.sv
// tb_agc_core: table, directed and randomized checks of agc_core against a cycle-stamp reference model
module tb_agc_core;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0, strt1 = 1'b0, strt2 = 1'b0, mstp = 1'b0, mstrtp = 1'b0, sby = 1'b0;
    logic [15:0] sa = '0;
    logic [55:0] rsv = '0;
    logic [11:0] tp, z;
    logic        mct, goj;
    logic [15:0] g;
    int          tot = 0, bad = 0;

    int          m_step = 0, m_resume = 1, m_asrt = 0, m_t01 = 0, m_cyc = 0;
    bit          m_halt = 0, m_goj = 0, m_pstrt = 0, m_pstep = 0, m_pend = 0;
    logic [11:0] m_z = '0;
    logic [15:0] m_g = '0;

    typedef struct {
        logic        rst_n;
        logic [15:0] sa;
        logic [11:0] tp;
        logic [11:0] z;
        logic [15:0] g;
    } vec_t;

    always #5 clk = ~clk;

    agc_core dut (
        .CLOCK(clk), .SIM_RST_n(rst_n), .STRT1(strt1), .STRT2(strt2), .MSTP(mstp), .MSTRTP(mstrtp), .SBY(sby),
        .SA01(sa[0]), .SA02(sa[1]), .SA03(sa[2]), .SA04(sa[3]), .SA05(sa[4]), .SA06(sa[5]), .SA07(sa[6]),
        .SA08(sa[7]), .SA09(sa[8]), .SA10(sa[9]), .SA11(sa[10]), .SA12(sa[11]), .SA13(sa[12]), .SA14(sa[13]),
        .SA16(sa[15]),
        .ALGA(rsv[0]), .C24A(rsv[1]), .C25A(rsv[2]), .C26A(rsv[3]), .C27A(rsv[4]), .C30A(rsv[5]),
        .C31A(rsv[6]), .C32A(rsv[7]), .C33A(rsv[8]), .C34A(rsv[9]), .C35A(rsv[10]), .C36A(rsv[11]),
        .C37P(rsv[12]), .C40P(rsv[13]), .C41P(rsv[14]), .C42P(rsv[15]), .C43P(rsv[16]), .C44P(rsv[17]),
        .CH01(rsv[18]), .CH02(rsv[19]), .CH03(rsv[20]), .CH04(rsv[21]), .CH05(rsv[22]), .CH06(rsv[23]),
        .CH07(rsv[24]), .CH08(rsv[25]), .CH09(rsv[26]), .CH10(rsv[27]), .CH11(rsv[28]), .CH12(rsv[29]),
        .CH13(rsv[30]), .CH14(rsv[31]), .CH15(rsv[32]), .CH16(rsv[33]),
        .MDT01(rsv[34]), .MDT02(rsv[35]), .MDT03(rsv[36]), .MDT04(rsv[37]), .MDT05(rsv[38]), .MDT06(rsv[39]),
        .MDT07(rsv[40]), .MDT08(rsv[41]), .MDT09(rsv[42]), .MDT10(rsv[43]), .MDT11(rsv[44]), .MDT12(rsv[45]),
        .MDT13(rsv[46]), .MDT14(rsv[47]), .MDT15(rsv[48]), .MDT16(rsv[49]),
        .XB0_n(rsv[50]), .XT0_n(rsv[51]), .YB0_n(rsv[52]), .YT0_n(rsv[53]), .VCC(rsv[54]), .GND(rsv[55]),
        .TP(tp), .MCT(mct), .GOJAM(goj), .G(g), .Z(z)
    );

    function automatic logic [11:0] tpb(input int s);
        return (s == 0) ? 12'h000 : 12'(12'h001 << (s - 1));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: step numbers 1..12 (0 = dark); GOJAM ends at a T12 once a T01 has been
    // shown at or after the cycle in which GOJAM was (re)asserted.
    task automatic model_edge();
        bit start, stepe;
        if (!rst_n) begin
            m_step = 0; m_resume = 1; m_halt = 0; m_goj = 0; m_z = '0; m_g = '0;
            m_pstrt = 0; m_pstep = 0; m_pend = 0; m_cyc++;
            return;
        end
        start = ((strt1 | strt2) && !m_pstrt) || m_pend;
        stepe = mstrtp && !m_pstep;
        m_pstrt = strt1 | strt2;
        m_pstep = mstrtp;
        m_cyc++;
        if (sby) begin
            m_pend = start;
            if (m_step != 0) m_resume = m_step;
            m_step = 0;
            return;
        end
        m_pend = 0;
        if (m_goj) m_g = '0;
        else if (m_step == 7) m_g = sa & 16'hBFFF;
        if (m_step == 12) begin
            m_z = m_goj ? 12'o4000 : m_z + 12'd1;
            if (m_goj && m_t01 >= m_asrt) m_goj = 0;
        end
        if (start) begin
            m_goj = 1;
            m_asrt = m_cyc;
        end
        if (m_step == 12) begin
            if (mstp) begin
                m_step = 0; m_halt = 1; m_resume = 1;
            end else m_step = 1;
        end else if (m_step != 0) m_step++;
        else if (!m_halt || !mstp || stepe) begin
            m_step = m_resume; m_halt = 0;
        end
        if (m_step == 1) m_t01 = m_cyc;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_tp(input int s);
        for (int i = 0; i < 40 && tp !== tpb(s); i++) tick();
        chk($sformatf("wait_T%0d", s), tp, tpb(s));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[29];
        int   n, errs;
        for (int r = 0; r < 5; r++) vt[r] = '{1'b0, 16'h0000, 12'h000, 12'h000, 16'h0000};
        for (int r = 0; r < 24; r++)
            vt[r + 5] = '{1'b1, 16'hD000, tpb(r % 12 + 1), 12'(r / 12), (r >= 7) ? 16'h9000 : 16'h0000};
        @(negedge clk);
        foreach (vt[i]) begin
            rst_n = vt[i].rst_n;
            sa    = vt[i].sa;
            rsv   = 56'({$urandom, $urandom});
            tick();
            chk("tbl_tp", tp, vt[i].tp);
            chk("tbl_mct", mct, vt[i].tp[11]);
            chk("tbl_gojam", goj, 0);
            chk("tbl_z", z, vt[i].z);
            chk("tbl_g", g, vt[i].g);
        end
        // standby in the middle of T05
        wait_tp(5);
        sby = 1'b1;
        tick();
        chk("sby_tp", tp, 0); chk("sby_z", z, 2); chk("sby_g", g, 16'h9000);
        sa = 16'h0000;
        repeat (3) tick();
        chk("sby_hold_tp", tp, 0); chk("sby_hold_z", z, 2); chk("sby_hold_g", g, 16'h9000);
        sby = 1'b0;
        tick();
        chk("sby_resume_tp", tp, tpb(5));
        tick();
        chk("sby_next_tp", tp, tpb(6));
        // five-cycle start pulse launched during T03
        wait_tp(3);
        strt1 = 1'b1;
        tick();
        chk("strt_gojam", goj, 1); chk("strt_tp", tp, tpb(4));
        repeat (4) tick();
        chk("strt_g_clear", g, 0);
        strt1 = 1'b0;
        n = 5;
        for (int i = 0; i < 40 && goj === 1'b1; i++) begin
            tick();
            if (goj === 1'b1) n++;
        end
        chk("gojam_len", n, 21); chk("gojam_end_tp", tp, tpb(1));
        chk("gojam_z", z, 12'o4000); chk("gojam_g", g, 0);
        // single sense-amp bit
        sa = 16'h1000;
        repeat (13) tick();
        chk("sa13_g", g, 16'h1000);
        sa = 16'h0000;
        repeat (13) tick();
        chk("sa13_clr", g, 0);
        // free run across the 7777 -> 0 wrap starting from the restart address
        wait_tp(1);
        chk("run_start_z", z, 12'o4003);
        errs = 0;
        for (int k = 1; k <= 2100 * 12; k++) begin
            tick();
            if (z !== 12'(12'o4003 + k / 12)) errs++;
        end
        chk("run_z_errs", errs, 0); chk("run_end_z", z, 12'd55); chk("run_end_tp", tp, tpb(1));
        // monitor stop then one step
        mstp = 1'b1;
        n = 0;
        for (int i = 0; i < 20 && tp !== 12'h000; i++) begin
            tick();
            n++;
        end
        chk("mstp_halt_n", n, 12); chk("mstp_z", z, 12'd56);
        repeat (4) tick();
        chk("mstp_hold_tp", tp, 0); chk("mstp_hold_z", z, 12'd56);
        mstrtp = 1'b1;
        tick();
        chk("mstep_t01", tp, tpb(1));
        for (int s = 2; s <= 12; s++) begin
            tick();
            chk("mstep_seq", tp, tpb(s));
        end
        tick();
        chk("mstep_rehalt", tp, 0); chk("mstep_z", z, 12'd57);
        mstrtp = 1'b0;
        tick();
        chk("mstep_still", tp, 0);
        mstp = 1'b0;
        tick();
        chk("mstp_release", tp, tpb(1));
        // start request arriving during standby
        sby = 1'b1; strt1 = 1'b1;
        tick();
        strt1 = 1'b0;
        tick();
        chk("sby_strt_latched", goj, 0);
        sby = 1'b0;
        tick();
        chk("sby_strt_act", goj, 1);
        for (int i = 0; i < 40 && goj === 1'b1; i++) tick();
        chk("sby_strt_end", goj, 0);
        // reset in the middle of a restart
        strt2 = 1'b1;
        tick();
        strt2 = 1'b0;
        repeat (3) tick();
        chk("rst_pre_gojam", goj, 1);
        rst_n = 1'b0;
        tick();
        chk("rst_tp", tp, 0); chk("rst_gojam", goj, 0); chk("rst_z", z, 0); chk("rst_g", g, 0);
        rst_n = 1'b1;
        tick();
        chk("rst_rel_tp", tp, tpb(1)); chk("rst_rel_gojam", goj, 0);
        // randomized run against the model
        rst_n = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < 4000 && bad < 20; i++) begin
            if ($urandom_range(19) == 0) sby = ~sby;
            if ($urandom_range(49) == 0) mstp = ~mstp;
            if ($urandom_range(5) == 0) mstrtp = ~mstrtp;
            if ($urandom_range(29) == 0) strt1 = ~strt1;
            if ($urandom_range(29) == 0) strt2 = ~strt2;
            rst_n = $urandom_range(699) != 0;
            sa    = 16'($urandom);
            rsv   = 56'({$urandom, $urandom});
            tick();
            chk("rnd_tp", tp, tpb(m_step));
            chk("rnd_mct", mct, m_step == 12);
            chk("rnd_gojam", goj, m_goj);
            chk("rnd_z", z, m_z);
            chk("rnd_g", g, m_g);
        end
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule
